// File: rtl/garage_input_cond.sv
// Input conditioning ahead of the garage door FSM: two-flop sync and debounce for the
// button and both limit switches, Active pulse and limit fault. Macro STUCK_BTN_EN adds btn_stuck.
module garage_input_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int STUCK_CYCLES    = 1024,
    parameter int STUCK_W         = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic up_lim_raw,
    input  logic dn_lim_raw,
    output logic Active,
    output logic Up_Max,
    output logic Dn_Max,
    output logic lim_fault,
    output logic btn_stuck
);

    localparam int NUM_IN  = 3;
    localparam int IDX_BTN = 0;
    localparam int IDX_UP  = 1;
    localparam int IDX_DN  = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject configurations where a counter could not reach its terminal value.
    generate
        if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (1 << CNT_W) - 1) ||
            (STUCK_CYCLES < 2) || (STUCK_CYCLES > (1 << STUCK_W))) begin : g_bad_cfg
            $error("garage_input_cond: parameter out of range");
        end
    endgenerate

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] st_vec;

    assign raw_vec = {dn_lim_raw, up_lim_raw, btn_raw};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_cond
            logic             s1_reg;
            logic             s2_reg;
            logic             st_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Any cycle where s2 agrees with the stable value restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    st_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg <= raw_vec[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == st_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        st_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign st_vec[gi] = st_reg;
        end
    endgenerate

    logic st_btn;
    logic st_up;
    logic st_dn;

    assign st_btn = st_vec[IDX_BTN];
    assign st_up  = st_vec[IDX_UP];
    assign st_dn  = st_vec[IDX_DN];

    logic active_reg;
    logic active_next;
    logic btn_prev_reg;
    logic fault_reg;
    logic fault_next;

    // A press landing during a limit fault still updates btn_prev, so it is consumed.
    always_comb begin
        fault_next  = st_up & st_dn;
        active_next = st_btn & ~btn_prev_reg & ~fault_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg   <= 1'b0;
            btn_prev_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            active_reg   <= active_next;
            btn_prev_reg <= st_btn;
            fault_reg    <= fault_next;
        end
    end

    assign Active    = active_reg;
    assign Up_Max    = st_up;
    assign Dn_Max    = st_dn;
    assign lim_fault = fault_reg;

`ifdef STUCK_BTN_EN
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

    logic [STUCK_W-1:0] stuck_cnt_reg;
    logic               stuck_reg;

    // Counter saturates at its terminal value; the flag holds until the button releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_cnt_reg <= '0;
            stuck_reg     <= 1'b0;
        end else if (!st_btn) begin
            stuck_cnt_reg <= '0;
            stuck_reg     <= 1'b0;
        end else if (stuck_cnt_reg == STUCK_LAST) begin
            stuck_reg <= 1'b1;
        end else begin
            stuck_cnt_reg <= stuck_cnt_reg + STUCK_W'(1);
        end
    end

    assign btn_stuck = stuck_reg;
`else
    assign btn_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_garage_input_cond.sv
// Directed bench for garage_input_cond with DEBOUNCE_CYCLES=4: table of input/expected
// records plus hand sequences for reset-while-pending and the optional stuck-button flag.
module tb_garage_input_cond;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic up_lim_raw;
    logic dn_lim_raw;
    logic Active;
    logic Up_Max;
    logic Dn_Max;
    logic lim_fault;
    logic btn_stuck;

    int pass_cnt = 0;
    int total    = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    garage_input_cond #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (5),
        .STUCK_CYCLES   (8),
        .STUCK_W        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .up_lim_raw(up_lim_raw),
        .dn_lim_raw(dn_lim_raw),
        .Active    (Active),
        .Up_Max    (Up_Max),
        .Dn_Max    (Dn_Max),
        .lim_fault (lim_fault),
        .btn_stuck (btn_stuck)
    );

    typedef struct {
        string name;
        int    btn;
        int    up;
        int    dn;
        int    n;
        int    e_act;
        int    e_up;
        int    e_dn;
        int    e_fault;
        int    e_pulses;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input int b, input int u, input int d,
                                input int n, input int ea, input int eu, input int ed,
                                input int ef, input int ep);
        vec_t v;
        v.name = nm; v.btn = b; v.up = u; v.dn = d; v.n = n;
        v.e_act = ea; v.e_up = eu; v.e_dn = ed; v.e_fault = ef; v.e_pulses = ep;
        vecs.push_back(v);
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (Active === 1'b1) pulses++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    initial begin
        reset      = 1'b1;
        btn_raw    = 1'b0;
        up_lim_raw = 1'b0;
        dn_lim_raw = 1'b0;
        step(3);
        check("reset_active", Active, 0);
        check("reset_up", Up_Max, 0);
        check("reset_dn", Dn_Max, 0);
        check("reset_fault", lim_fault, 0);
        check("reset_stuck", btn_stuck, 0);
        reset = 1'b0;

        //   name             btn up dn  n  act up dn flt pulses
        add("idle",            0, 0, 0,  5, 0, 0, 0, 0, 0);
        add("press_wait",      1, 0, 0,  6, 0, 0, 0, 0, 0);
        add("press_pulse",     1, 0, 0,  1, 1, 0, 0, 0, 1);
        add("hold",            1, 0, 0, 50, 0, 0, 0, 0, 0);
        add("release",         0, 0, 0, 10, 0, 0, 0, 0, 0);
        add("bounce_h1",       1, 0, 0,  2, 0, 0, 0, 0, 0);
        add("bounce_l1",       0, 0, 0,  2, 0, 0, 0, 0, 0);
        add("bounce_h2",       1, 0, 0,  2, 0, 0, 0, 0, 0);
        add("bounce_l2",       0, 0, 0,  2, 0, 0, 0, 0, 0);
        add("settle_wait",     1, 0, 0,  6, 0, 0, 0, 0, 0);
        add("settle_pulse",    1, 0, 0,  1, 1, 0, 0, 0, 1);
        add("settle_hold",     1, 0, 0, 10, 0, 0, 0, 0, 0);
        add("release2",        0, 0, 0, 10, 0, 0, 0, 0, 0);
        add("dn_wait",         0, 0, 1,  5, 0, 0, 0, 0, 0);
        add("dn_rise",         0, 0, 1,  1, 0, 0, 1, 0, 0);
        add("dn_glitch3",      0, 0, 0,  3, 0, 0, 1, 0, 0);
        add("dn_restore",      0, 0, 1, 10, 0, 0, 1, 0, 0);
        add("dn_release",      0, 0, 0, 10, 0, 0, 0, 0, 0);
        add("up_high4",        0, 1, 0,  4, 0, 0, 0, 0, 0);
        add("up_lands",        0, 0, 0,  2, 0, 1, 0, 0, 0);
        add("up_drops",        0, 0, 0, 10, 0, 0, 0, 0, 0);
        add("both_lim",        0, 1, 1, 10, 0, 1, 1, 1, 0);
        add("press_in_fault",  1, 1, 1, 20, 0, 1, 1, 1, 0);
        add("up_off_wait",     1, 0, 1,  6, 0, 0, 1, 1, 0);
        add("fault_clear",     1, 0, 1,  1, 0, 0, 1, 0, 0);
        add("no_retro",        1, 0, 1, 10, 0, 0, 1, 0, 0);
        add("release3",        0, 0, 0, 10, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw    = (vecs[i].btn != 0);
            up_lim_raw = (vecs[i].up != 0);
            dn_lim_raw = (vecs[i].dn != 0);
            pulses     = 0;
            step(vecs[i].n);
            $display("vec %0d %s: btn=%0d up=%0d dn=%0d n=%0d -> Active=%0b Up_Max=%0b Dn_Max=%0b lim_fault=%0b pulses=%0d",
                     i, vecs[i].name, vecs[i].btn, vecs[i].up, vecs[i].dn, vecs[i].n,
                     Active, Up_Max, Dn_Max, lim_fault, pulses);
            check({vecs[i].name, ".Active"}, Active, vecs[i].e_act);
            check({vecs[i].name, ".Up_Max"}, Up_Max, vecs[i].e_up);
            check({vecs[i].name, ".Dn_Max"}, Dn_Max, vecs[i].e_dn);
            check({vecs[i].name, ".lim_fault"}, lim_fault, vecs[i].e_fault);
            check({vecs[i].name, ".pulses"}, pulses, vecs[i].e_pulses);
        end

        // Reset sampled on the edge where the pulse would have been issued.
        btn_raw = 1'b1;
        pulses  = 0;
        step(6);
        check("rst_pending_pre", Active, 0);
        reset   = 1'b1;
        btn_raw = 1'b0;
        step(1);
        check("rst_pending_active", Active, 0);
        check("rst_pending_up", Up_Max, 0);
        reset = 1'b0;
        step(20);
        check("rst_pending_pulses", pulses, 0);
        $display("seq rst_pending: pulses=%0d", pulses);

        // Partial debounce count must be discarded by reset: full latency again afterwards.
        btn_raw = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        reset  = 1'b0;
        pulses = 0;
        step(6);
        check("rst_partial_early", pulses, 0);
        step(1);
        check("rst_partial_pulse", Active, 1);
        check("rst_partial_count", pulses, 1);
        btn_raw = 1'b0;
        step(10);
        $display("seq rst_partial: pulses=%0d", pulses);

`ifdef STUCK_BTN_EN
        btn_raw = 1'b1;
        step(6);
        check("stuck_at_st_rise", btn_stuck, 0);
        step(7);
        check("stuck_before_8", btn_stuck, 0);
        step(1);
        check("stuck_at_8", btn_stuck, 1);
        step(5);
        check("stuck_held", btn_stuck, 1);
        btn_raw = 1'b0;
        step(5);
        check("stuck_release_wait", btn_stuck, 1);
        step(1);
        check("stuck_st_fall_edge", btn_stuck, 1);
        step(1);
        check("stuck_cleared", btn_stuck, 0);
        step(5);
        $display("seq stuck: btn_stuck=%0b", btn_stuck);
`else
        btn_raw = 1'b1;
        step(40);
        check("stuck_disabled", btn_stuck, 0);
        btn_raw = 1'b0;
        step(10);
        $display("seq stuck_disabled: btn_stuck=%0b", btn_stuck);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
